// File: rtl/filter_kernel_sdiv_pkg.sv
// Shared types and constants for the sequential signed divider used after the
// filter accumulator.
package filter_kernel_sdiv_pkg;

  localparam int DIVIDEND_WIDTH_DEF = 61;
  localparam int DIVISOR_WIDTH_DEF  = 32;
  localparam int CNT_WIDTH          = $clog2(DIVIDEND_WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Iteration counter width for an arbitrary dividend width
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/filter_kernel_sdiv_step.sv
// One radix-2 restoring division iteration on an unsigned partial remainder.
module filter_kernel_sdiv_step
  import filter_kernel_sdiv_pkg::*;
#(
  parameter int DIVISOR_WIDTH = DIVISOR_WIDTH_DEF
) (
  input  logic [DIVISOR_WIDTH:0]   prem,
  input  logic                     dbit,
  input  logic [DIVISOR_WIDTH-1:0] abs_div,
  output logic [DIVISOR_WIDTH:0]   prem_next,
  output logic                     qbit
);

  logic [DIVISOR_WIDTH+1:0] shifted;

  // Shift in the next dividend bit and subtract the divisor when it fits
  always_comb begin
    shifted = {prem, dbit};
    if (shifted >= {2'b00, abs_div}) begin
      qbit      = 1'b1;
      prem_next = (DIVISOR_WIDTH+1)'(shifted - {2'b00, abs_div});
    end else begin
      qbit      = 1'b0;
      prem_next = shifted[DIVISOR_WIDTH:0];
    end
  end

endmodule

// File: rtl/filter_kernel_sdiv_61s_32s_seq.sv
// Multi-cycle signed restoring divider (truncating, remainder follows dividend).
// Optional div_by_zero output enabled by FILTER_KERNEL_SDIV_DZ_FLAG_EN.
module filter_kernel_sdiv_61s_32s_seq
  import filter_kernel_sdiv_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_DEF,
  parameter int DIVISOR_WIDTH  = DIVISOR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder
`ifdef FILTER_KERNEL_SDIV_DZ_FLAG_EN
  ,
  output logic                      div_by_zero
`endif
);

  localparam int CW = cnt_width(DIVIDEND_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DIVIDEND_WIDTH - 1);

  state_t                    state_r;
  logic [CW-1:0]             cnt_r;
  logic [DIVIDEND_WIDTH-1:0] dq_r;
  logic [DIVISOR_WIDTH:0]    prem_r;
  logic [DIVISOR_WIDTH-1:0]  abs_div_r;
  logic [DIVISOR_WIDTH-1:0]  dvd_low_r;
  logic                      neg_q_r;
  logic                      neg_r_r;
  logic                      dz_r;
  logic                      ovf_r;

  logic [DIVIDEND_WIDTH-1:0] abs_dvd;
  logic [DIVISOR_WIDTH-1:0]  abs_div;
  logic [DIVISOR_WIDTH:0]    prem_next;
  logic                      qbit;

  // Unsigned negation keeps the most-negative operand exact (2^(w-1) as unsigned)
  assign abs_dvd  = dividend[DIVIDEND_WIDTH-1] ? -dividend : dividend;
  assign abs_div  = divisor[DIVISOR_WIDTH-1] ? -divisor : divisor;
  assign in_ready = reset && (state_r == IDLE);

  filter_kernel_sdiv_step #(
    .DIVISOR_WIDTH(DIVISOR_WIDTH)
  ) u_step (
    .prem      (prem_r),
    .dbit      (dq_r[DIVIDEND_WIDTH-1]),
    .abs_div   (abs_div_r),
    .prem_next (prem_next),
    .qbit      (qbit)
  );

  // Control FSM and datapath registers; dq_r holds the dividend shifting out and the quotient shifting in
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      dq_r      <= {DIVIDEND_WIDTH{1'b0}};
      prem_r    <= {(DIVISOR_WIDTH+1){1'b0}};
      abs_div_r <= {DIVISOR_WIDTH{1'b0}};
      dvd_low_r <= {DIVISOR_WIDTH{1'b0}};
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      dz_r      <= 1'b0;
      ovf_r     <= 1'b0;
      out_valid <= 1'b0;
      quotient  <= {DIVIDEND_WIDTH{1'b0}};
      remainder <= {DIVISOR_WIDTH{1'b0}};
`ifdef FILTER_KERNEL_SDIV_DZ_FLAG_EN
      div_by_zero <= 1'b0;
`endif
    end else if (ce) begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            dq_r      <= abs_dvd;
            abs_div_r <= abs_div;
            dvd_low_r <= dividend[DIVISOR_WIDTH-1:0];
            neg_q_r   <= dividend[DIVIDEND_WIDTH-1] ^ divisor[DIVISOR_WIDTH-1];
            neg_r_r   <= dividend[DIVIDEND_WIDTH-1];
            dz_r      <= (divisor == {DIVISOR_WIDTH{1'b0}});
            ovf_r     <= (dividend == {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}}) &&
                         (divisor == {DIVISOR_WIDTH{1'b1}});
            prem_r    <= {(DIVISOR_WIDTH+1){1'b0}};
            cnt_r     <= {CW{1'b0}};
            state_r   <= BUSY;
          end
        end
        BUSY: begin
          prem_r <= prem_next;
          dq_r   <= {dq_r[DIVIDEND_WIDTH-2:0], qbit};
          if (cnt_r == LAST) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= FIXUP;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        FIXUP: begin
          if (dz_r) begin
            quotient  <= {DIVIDEND_WIDTH{1'b1}};
            remainder <= dvd_low_r;
          end else if (ovf_r) begin
            quotient  <= {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}};
            remainder <= {DIVISOR_WIDTH{1'b0}};
          end else begin
            quotient  <= neg_q_r ? -dq_r : dq_r;
            remainder <= neg_r_r ? -prem_r[DIVISOR_WIDTH-1:0] : prem_r[DIVISOR_WIDTH-1:0];
          end
`ifdef FILTER_KERNEL_SDIV_DZ_FLAG_EN
          div_by_zero <= dz_r;
`endif
          out_valid <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filter_kernel_sdiv_61s_32s_seq.sv
// Randomised self-checking bench for the sequential signed divider against an
// integer-arithmetic reference model.
module tb_filter_kernel_sdiv_61s_32s_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [60:0] dividend = 61'd0;
  logic [31:0] divisor = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [60:0] quotient;
  logic [31:0] remainder;
`ifdef FILTER_KERNEL_SDIV_DZ_FLAG_EN
  logic        div_by_zero;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  filter_kernel_sdiv_61s_32s_seq dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef FILTER_KERNEL_SDIV_DZ_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed 64-bit division, truncating, with the divide-by-zero rule
  task automatic model(input logic [60:0] a, input logic [31:0] b,
                       output logic [60:0] q, output logic [31:0] r);
    longint la;
    longint lb;
    longint lq;
    longint lr;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (lb == 64'sd0) begin
      q = {61{1'b1}};
      r = a[31:0];
    end else begin
      lq = la / lb;
      lr = la % lb;
      q = lq[60:0];
      r = lr[31:0];
    end
  endtask

  function automatic logic [60:0] rnd_dvd();
    logic [63:0] w;
    int m;
    w = {$urandom, $urandom};
    m = $urandom_range(0, 7);
    case (m)
      0: return 61'd1;
      1: return {61{1'b1}};
      2: return {1'b0, {60{1'b1}}};
      3: return {1'b1, {60{1'b0}}};
      4: return w[60:0] >> $urandom_range(0, 56);
      5: return -(61'(w[15:0]));
      default: return w[60:0];
    endcase
  endfunction

  function automatic logic [31:0] rnd_div();
    logic [31:0] w;
    int m;
    w = $urandom;
    m = $urandom_range(0, 9);
    case (m)
      0: return 32'd0;
      1: return 32'd1;
      2: return {32{1'b1}};
      3: return 32'h7fff_ffff;
      4: return 32'h8000_0000;
      5: return w >> $urandom_range(0, 28);
      6: return -(32'(w[7:0]) + 32'd1);
      default: return w;
    endcase
  endfunction

  task automatic run(input logic [60:0] a, input logic [31:0] b, input bit gap,
                     input int hold, input bit rdy_busy);
    logic [60:0] eq;
    logic [31:0] er;
    int lat;
    longint prod;
    model(a, b, eq, er);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    out_ready = rdy_busy;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("in_ready_busy", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (gap && lat == 20) ce = 1'b0;
      if (gap && lat == 25) ce = 1'b1;
    end
    check("latency", 64'(lat), gap ? 64'd67 : 64'd62);
    check("quotient", 64'(quotient), 64'(eq));
    check("remainder", 64'(remainder), 64'(er));
`ifdef FILTER_KERNEL_SDIV_DZ_FLAG_EN
    check("div_by_zero", 64'(div_by_zero), 64'(b == 32'd0));
`endif
    if (b != 32'd0) begin
      prod = longint'($signed(quotient)) * longint'($signed(b)) + longint'($signed(remainder));
      check("identity", 64'(prod[60:0]), 64'(a));
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = (i % 3 == 0);
      dividend = ~a;
      @(posedge clk);
      #1;
      check("hold_quotient", 64'(quotient), 64'(eq));
      check("hold_remainder", 64'(remainder), 64'(er));
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run(61'd100, 32'd7, 1'b0, 10, 1'b0);
    run(-61'd100, 32'd7, 1'b0, 0, 1'b0);
    run(61'd100, -32'd7, 1'b0, 0, 1'b1);
    run(-61'd100, -32'd7, 1'b0, 0, 1'b0);
    run(61'd5, 32'd0, 1'b0, 0, 1'b0);
    run({1'b1, {60{1'b0}}}, {32{1'b1}}, 1'b0, 0, 1'b0);
    run(61'd987654321012345, 32'd12345, 1'b1, 0, 1'b0);

    // Abort an operation around iteration 30
    dividend = 61'd123456789;
    divisor  = 32'd789;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("post_abort_in_ready", 64'(in_ready), 64'd1);
    check("post_abort_out_valid", 64'(out_valid), 64'd0);
    check("post_abort_quotient", 64'(quotient), 64'd0);
    @(posedge clk);
    #1;
    run(61'd1000, 32'd3, 1'b0, 0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      run(rnd_dvd(), rnd_div(), ($urandom_range(0, 9) == 0), 0, ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
